// File: rtl/result_reporter_pkg.sv
// rtl/result_reporter_pkg.sv - shared constants and types for the result reporter
// RESULT_CHECKSUM_EN adds a seventh XOR checksum byte to every frame.
package result_reporter_pkg;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;

`ifdef RESULT_CHECKSUM_EN
  localparam int FRAME_BYTES = 7;

  // Checksum covers the pe_id byte and the four nonce bytes, not the sync byte.
  function automatic logic [7:0] frame_xor(input logic [3:0] pe_id, input logic [31:0] nonce);
    return {4'h0, pe_id} ^ nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
  endfunction
`else
  localparam int FRAME_BYTES = 6;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_NEXT = 2'd3
  } state_t;

endpackage

// File: rtl/result_reporter_if.sv
// rtl/result_reporter_if.sv - found-nonce handshake between processing elements and the reporter
// A PE holds found_valid and its nonce until it sees found_ack at a clock edge.
interface result_reporter_if #(
  parameter int NUM_PE = 4
);
  logic [NUM_PE-1:0]    found_valid;
  logic [32*NUM_PE-1:0] found_nonce;
  logic [NUM_PE-1:0]    found_ack;

  modport master (output found_valid, output found_nonce, input found_ack);
  modport slave  (input found_valid, input found_nonce, output found_ack);
endinterface

// File: rtl/result_reporter_uart_tx_byte.sv
// rtl/result_reporter_uart_tx_byte.sv - 8N1 byte serialiser for the result reporter
// start is taken only while idle; done pulses during the final stop-bit cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          active;

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      tx       <= 1'b1;
      done     <= 1'b0;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (start) begin
          active   <= 1'b1;
          tx       <= 1'b0;
          shreg    <= data;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      end else begin
        // Raised one cycle early so the pulse lines up with the last stop-bit cycle.
        if (bit_cnt == 4'd9 && baud_cnt == BAUD_PRE) begin
          done <= 1'b1;
        end
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd8) begin
              tx <= 1'b1;
            end else begin
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
            end
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/result_reporter.sv
// rtl/result_reporter.sv - round-robin collector of found nonces, framed out over an 8N1 UART
// RESULT_CHECKSUM_EN appends an XOR checksum byte to each frame.
module result_reporter
  import result_reporter_pkg::*;
#(
  parameter int NUM_PE       = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                CLK,
  input  logic                nreset,
  result_reporter_if.slave    pe,
  output logic                uart_tx,
  output logic                busy,
  output logic [15:0]         frames_sent
);

  state_t        state;
  logic [3:0]    rr_ptr;
  logic [3:0]    pe_id;
  logic [31:0]   nonce_q;
  logic [2:0]    byte_idx;

  logic [15:0]   valid_pad;
  logic          grant_any;
  logic [3:0]    grant_idx;
  logic [NUM_PE-1:0] grant_vec;
  logic [31:0]   nonce_sel;
  logic [4:0]    search_idx;
  logic [4:0]    grant_inc;
  logic [3:0]    ptr_next;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done;

  assign valid_pad = 16'(pe.found_valid);

  // Circular search starting at rr_ptr; the first hit wins.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = 4'd0;
    search_idx = 5'd0;
    for (int off = 0; off < NUM_PE; off++) begin
      search_idx = {1'b0, rr_ptr} + 5'(off);
      if (search_idx >= 5'(NUM_PE)) begin
        search_idx = search_idx - 5'(NUM_PE);
      end
      if (!grant_any && valid_pad[search_idx[3:0]]) begin
        grant_any = 1'b1;
        grant_idx = search_idx[3:0];
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    nonce_sel = 32'd0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant_any && grant_idx == 4'(i)) begin
        grant_vec[i] = 1'b1;
        nonce_sel    = pe.found_nonce[32*i +: 32];
      end
    end
  end

  assign grant_inc = {1'b0, grant_idx} + 5'd1;
  assign ptr_next  = (grant_inc == 5'(NUM_PE)) ? 4'd0 : grant_inc[3:0];

  // The ack marks the capturing edge, so it must vanish the moment reset asserts.
  assign pe.found_ack = (state == S_IDLE && nreset) ? grant_vec : '0;

  always_comb begin
    case (byte_idx)
      3'd1:    tx_data = {4'h0, pe_id};
      3'd2:    tx_data = nonce_q[31:24];
      3'd3:    tx_data = nonce_q[23:16];
      3'd4:    tx_data = nonce_q[15:8];
      3'd5:    tx_data = nonce_q[7:0];
`ifdef RESULT_CHECKSUM_EN
      3'd6:    tx_data = frame_xor(pe_id, nonce_q);
`endif
      default: tx_data = FRAME_SYNC;
    endcase
  end

  assign tx_start = (state == S_LOAD);

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      rr_ptr      <= 4'd0;
      pe_id       <= 4'd0;
      nonce_q     <= 32'd0;
      byte_idx    <= 3'd0;
      busy        <= 1'b0;
      frames_sent <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            pe_id   <= grant_idx;
            nonce_q <= nonce_sel;
            rr_ptr  <= ptr_next;
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: state <= S_SEND;
        S_SEND: begin
          if (tx_done) begin
            if (byte_idx == 3'(FRAME_BYTES - 1)) begin
              state <= S_NEXT;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= S_LOAD;
            end
          end
        end
        S_NEXT: begin
          frames_sent <= frames_sent + 16'd1;
          byte_idx    <= 3'd0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .CLK    (CLK),
    .nreset (nreset),
    .start  (tx_start),
    .data   (tx_data),
    .tx     (uart_tx),
    .done   (tx_done)
  );

endmodule

// File: tb/tb_result_reporter.sv
// tb/tb_result_reporter.sv - randomized self-checking bench for result_reporter
// Reference model predicts the whole line waveform from frame bytes and bit timing.
module tb_result_reporter;

  localparam int NPE = 4;
  localparam int CPB = 4;
  localparam int W   = 10 * CPB + 1;
`ifdef RESULT_CHECKSUM_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int FRAME_LEN = 2 + NB * W + 1;

  logic        CLK = 1'b0;
  logic        nreset = 1'b0;
  logic        uart_tx;
  logic        busy;
  logic [15:0] frames_sent;
  logic [31:0] nonce_arr [NPE];

  result_reporter_if #(.NUM_PE(NPE)) pe_if ();

  result_reporter #(
    .NUM_PE       (NPE),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLK         (CLK),
    .nreset      (nreset),
    .pe          (pe_if),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < NPE; i++) pe_if.found_nonce[32*i +: 32] = nonce_arr[i];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic          m_in;
  int            m_c;
  int            m_ptr;
  logic [15:0]   m_frames;
  logic [7:0]    m_bytes [7];
  logic [NPE-1:0] acked;
  int            grants [$];
  int            gcyc [$];
  int            cyc;
  int            busy_cnt;
  int            req_pct;
  int            wd_pct;

  function automatic int rr_pick(input logic [NPE-1:0] v, input int ptr);
    for (int off = 0; off < NPE; off++) begin
      if (v[(ptr + off) % NPE]) return (ptr + off) % NPE;
    end
    return -1;
  endfunction

  function automatic logic exp_tx(input int c);
    int k, off, b;
    if (c < 1 || c > NB * W) return 1'b1;
    k   = (c - 1) / W;
    off = (c - 1) % W;
    if (off == 0) return 1'b1;
    b = (off - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_bytes[k][b-1];
  endfunction

  task automatic step();
    logic [NPE-1:0] exp_ack;
    logic [31:0]    n;
    int             g;
    @(negedge CLK);
    cyc++;
    exp_ack = '0;
    g = -1;
    if (!nreset) begin
      check("rst_ack", 32'(pe_if.found_ack), 32'd0);
      check("rst_tx", 32'(uart_tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frames", 32'(frames_sent), 32'd0);
      m_in = 1'b0; m_c = 0; m_ptr = 0; m_frames = 16'd0; busy_cnt = 0; acked = '0;
    end else begin
      if (!m_in) g = rr_pick(pe_if.found_valid, m_ptr);
      if (g >= 0) exp_ack[g] = 1'b1;
      check("found_ack", 32'(pe_if.found_ack), 32'(exp_ack));
      check("uart_tx", 32'(uart_tx), 32'(m_in ? exp_tx(m_c) : 1'b1));
      check("busy", 32'(busy), 32'(m_in));
      check("frames_sent", 32'(frames_sent), 32'(m_frames));
      if (busy) busy_cnt++;
      else if (busy_cnt > 0) begin
        check("busy_len", busy_cnt, FRAME_LEN - 2);
        busy_cnt = 0;
      end
      if (g >= 0) begin
        n = nonce_arr[g];
        m_bytes[0] = 8'hA5;
        m_bytes[1] = 8'(g);
        m_bytes[2] = n[31:24];
        m_bytes[3] = n[23:16];
        m_bytes[4] = n[15:8];
        m_bytes[5] = n[7:0];
        m_bytes[6] = m_bytes[1] ^ m_bytes[2] ^ m_bytes[3] ^ m_bytes[4] ^ m_bytes[5];
        m_ptr = (g + 1) % NPE;
        m_in  = 1'b1;
        m_c   = 1;
        acked[g] = 1'b1;
        grants.push_back(g);
        gcyc.push_back(cyc);
      end else if (m_in) begin
        if (m_c == NB * W + 1) begin
          m_in = 1'b0;
          m_frames = m_frames + 16'd1;
        end else begin
          m_c++;
        end
      end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < NPE; i++) begin
      if (acked[i]) pe_if.found_valid[i] = 1'b0;
    end
    acked = '0;
    for (int i = 0; i < NPE; i++) begin
      if (!pe_if.found_valid[i] && int'($urandom_range(99)) < req_pct) begin
        nonce_arr[i] = $urandom;
        pe_if.found_valid[i] = 1'b1;
      end else if (pe_if.found_valid[i] && int'($urandom_range(99)) < wd_pct) begin
        pe_if.found_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic apply_reset(input int n);
    nreset = 1'b0;
    repeat (n) step();
    nreset = 1'b1;
  endtask

  initial begin
    logic [31:0] tmp;
    logic        found;
    pe_if.found_valid = '0;
    for (int i = 0; i < NPE; i++) nonce_arr[i] = 32'd0;
    m_in = 1'b0; m_c = 0; m_ptr = 0; m_frames = 16'd0; acked = '0;
    cyc = 0; busy_cnt = 0; req_pct = 0; wd_pct = 0;

    apply_reset(3);
    repeat (1000) step();

    nonce_arr[2] = 32'h1234ABCD;
    pe_if.found_valid = 4'b0100;
    repeat (FRAME_LEN + 10) step();
    check("single_grants", grants.size(), 1);
    if (grants.size() >= 1) check("single_pe", grants[0], 2);
    check("single_frames", 32'(frames_sent), 32'd1);

    apply_reset(2);
    grants.delete();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NPE; i++) nonce_arr[i] = $urandom;
      pe_if.found_valid = 4'b1111;
      repeat (4 * FRAME_LEN + 20) step();
    end
    check("rr_count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) check("rr_order", grants[i], i % 4);
    check("rr_frames", 32'(frames_sent), 32'd8);

    grants.delete();
    gcyc.delete();
    nonce_arr[3] = $urandom;
    pe_if.found_valid[3] = 1'b1;
    repeat (100) step();
    nonce_arr[1] = $urandom;
    pe_if.found_valid[1] = 1'b1;
    repeat (2 * FRAME_LEN + 10) step();
    check("mid_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check("mid_first", grants[0], 3);
      check("mid_second", grants[1], 1);
      check("mid_spacing", gcyc[1] - gcyc[0], FRAME_LEN - 1);
    end

    grants.delete();
    req_pct = 4;
    wd_pct  = 1;
    repeat (8000) step();
    req_pct = 0;
    wd_pct  = 0;
    pe_if.found_valid = '0;
    repeat (FRAME_LEN + 5) step();
    check("rand_activity", 32'(grants.size() > 10), 32'd1);

    tmp = $urandom;
    nonce_arr[1] = {8'h5A, 8'h00, tmp[15:0]};
    pe_if.found_valid = 4'b0010;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step();
      if (m_in && m_c >= 1 && m_c <= NB * W && (m_c - 1) / W == 3 && exp_tx(m_c) == 1'b0) found = 1'b1;
    end
    check("rst_point_found", 32'(found), 32'd1);
    check("pre_reset_tx", 32'(uart_tx), 32'd0);
    pe_if.found_valid = 4'b0010;
    nreset = 1'b0;
    #1;
    check("async_tx", 32'(uart_tx), 32'd1);
    check("async_ack", 32'(pe_if.found_ack), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_frames", 32'(frames_sent), 32'd0);
    pe_if.found_valid = '0;
    repeat (2) step();
    nreset = 1'b1;
    repeat (50) step();
    check("post_rst_frames", 32'(frames_sent), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
